// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/host data-RAM port arbiter.
package mem_arb_pkg;
  localparam int STARVE_W = 8;
  localparam int HOST_AW  = 32;
  localparam int HOST_DW  = 32;

  typedef enum logic [1:0] {IDLE, PEND, ACK} arb_state_t;

  typedef struct packed {
    logic               we;
    logic [HOST_AW-1:0] addr;
    logic [HOST_DW-1:0] wdata;
  } host_req_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle around the arbiter: CPU MEM port, host req/ack port and RAM port.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic                cpu_mem_we;
  logic                cpu_mem_read;
  logic [AW-1:0]       cpu_mem_wa;
  logic [DW-1:0]       cpu_mem_din;
  logic [DW-1:0]       cpu_mem_data;
  logic                cpu_halt;
  logic                host_req;
  logic                host_we;
  logic [AW-1:0]       host_addr;
  logic [DW-1:0]       host_wdata;
  logic                host_busy;
  logic                host_ack;
  logic [DW-1:0]       host_rdata;
  logic                host_starve;
  logic [STARVE_W-1:0] starve_cnt;
  logic                ram_we;
  logic [AW-1:0]       ram_addr;
  logic [DW-1:0]       ram_din;
  logic [DW-1:0]       ram_dout;

  modport slave (
    input  cpu_mem_we, cpu_mem_read, cpu_mem_wa, cpu_mem_din, cpu_halt,
           host_req, host_we, host_addr, host_wdata, ram_dout,
    output cpu_mem_data, host_busy, host_ack, host_rdata, host_starve,
           starve_cnt, ram_we, ram_addr, ram_din
  );

  modport master (
    output cpu_mem_we, cpu_mem_read, cpu_mem_wa, cpu_mem_din, cpu_halt,
           host_req, host_we, host_addr, host_wdata, ram_dout,
    input  cpu_mem_data, host_busy, host_ack, host_rdata, host_starve,
           starve_cnt, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones; exposes next value.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_cnt_nxt
);
  logic [W-1:0] r_cnt, w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (i_clr)
      w_nxt = '0;
    else if (i_inc && (r_cnt != {W{1'b1}}))
      w_nxt = r_cnt + W'(1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_nxt;

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_nxt;
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data RAM shared by the stall-less CPU MEM stage (always wins)
// and a host req/ack port served only in CPU-idle or halted cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  arb_state_t          r_state, w_state_nxt;
  host_req_t           r_held;
  logic [DW-1:0]       r_rdata;
  logic                r_starve;
  logic                w_cpu_active, w_accept, w_serve, w_inc;
  logic                w_ram_we;
  logic [AW-1:0]       w_ram_addr;
  logic [DW-1:0]       w_ram_din;
  logic [STARVE_W-1:0] w_cnt, w_cnt_nxt;

  // A halted CPU may leave strobes stuck high; they must not block the host.
  assign w_cpu_active = (bus.cpu_mem_we | bus.cpu_mem_read) & ~bus.cpu_halt;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_serve     = 1'b0;
    w_inc       = 1'b0;
    w_ram_we    = w_cpu_active & bus.cpu_mem_we;
    w_ram_addr  = bus.cpu_mem_wa;
    w_ram_din   = bus.cpu_mem_din;
    unique case (r_state)
      PEND: begin
        if (w_cpu_active) begin
          w_inc = 1'b1;
        end else begin
          w_serve     = 1'b1;
          w_ram_we    = r_held.we;
          w_ram_addr  = AW'(r_held.addr);
          w_ram_din   = DW'(r_held.wdata);
          w_state_nxt = ACK;
        end
      end
      default: begin
        if (bus.host_req) begin
          w_accept    = 1'b1;
          w_state_nxt = PEND;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_held   <= '0;
      r_rdata  <= '0;
      r_starve <= 1'b0;
    end else begin
      if (w_accept)
        r_held <= '{we: bus.host_we, addr: HOST_AW'(bus.host_addr),
                    wdata: HOST_DW'(bus.host_wdata)};
      if (w_serve && !r_held.we)
        r_rdata <= bus.ram_dout;
      // Tracks the count's next value so the flag rises with the count itself.
      r_starve <= (w_cnt_nxt >= STARVE_W'(STARVE_LIMIT));
    end

  sat_counter #(.W(STARVE_W)) u_starve_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_accept),
    .i_inc     (w_inc),
    .o_cnt     (w_cnt),
    .o_cnt_nxt (w_cnt_nxt)
  );

  assign bus.cpu_mem_data = bus.ram_dout;
  assign bus.host_busy    = (r_state == PEND);
  assign bus.host_ack     = (r_state == ACK);
  assign bus.host_rdata   = r_rdata;
  assign bus.host_starve  = r_starve;
  assign bus.starve_cnt   = w_cnt;
  assign bus.ram_we       = w_ram_we;
  assign bus.ram_addr     = w_ram_addr;
  assign bus.ram_din      = w_ram_din;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk, rst, mem_clr;
  int          checks, errors;
  logic [31:0] mem [256];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(16)) dut (
    .clk (clk), .rst (rst), .bus (bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (bus.ram_we) mem[bus.ram_addr[7:0]] <= bus.ram_din;
  end
  assign bus.ram_dout = mem[bus.ram_addr[7:0]];

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_mem_we = 0; bus.cpu_mem_read = 0; bus.cpu_mem_wa = '0; bus.cpu_mem_din = '0;
    bus.cpu_halt = 0; bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1; mem_clr = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (bus.host_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", bus.host_busy); end
    if (bus.host_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %0b want 0", bus.host_ack); end
    if (bus.host_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.host_rdata); end
    if (bus.starve_cnt !== 8'h0) begin errors++; $display("FAIL rst_cnt got %0d want 0", bus.starve_cnt); end
    if (bus.host_starve !== 1'b0) begin errors++; $display("FAIL rst_starve got %0b want 0", bus.host_starve); end
    mem_clr = 0; rst = 0;
    next_cycle();
  endtask

  task automatic test_host_write();
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 32'h40; bus.host_wdata = 32'hDEADBEEF;
    next_cycle();
    bus.host_req = 0;
    @(negedge clk);
    checks += 4;
    if (bus.host_busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %0b want 1", bus.host_busy); end
    if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL wr_ram_we got %0b want 1", bus.ram_we); end
    if (bus.ram_addr !== 32'h40) begin errors++; $display("FAIL wr_ram_addr got %h want 40", bus.ram_addr); end
    if (bus.ram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_ram_din got %h want deadbeef", bus.ram_din); end
    next_cycle();
    @(negedge clk);
    checks += 3;
    if (bus.host_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %0b want 1", bus.host_ack); end
    if (bus.starve_cnt !== 8'd0) begin errors++; $display("FAIL wr_cnt got %0d want 0", bus.starve_cnt); end
    if (mem[8'h40] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem got %h want deadbeef", mem[8'h40]); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.host_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %0b want 0", bus.host_ack); end
    next_cycle();
  endtask

  task automatic test_starve();
    bus.cpu_mem_read = 1; bus.cpu_mem_wa = 32'h10;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 32'h40;
    next_cycle();
    bus.host_req = 0;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      @(negedge clk);
      checks += 3;
      if (bus.host_busy !== 1'b1) begin errors++; $display("FAIL stv_busy[%0d] got %0b want 1", i, bus.host_busy); end
      if (bus.starve_cnt !== 8'(i)) begin errors++; $display("FAIL stv_cnt got %0d want %0d", bus.starve_cnt, i); end
      if (bus.host_starve !== (i >= 16)) begin errors++; $display("FAIL stv_flag[%0d] got %0b want %0b", i, bus.host_starve, i >= 16); end
    end
    bus.cpu_mem_read = 0;
    next_cycle();
    @(negedge clk);
    checks += 4;
    if (bus.host_ack !== 1'b1) begin errors++; $display("FAIL stv_ack got %0b want 1", bus.host_ack); end
    if (bus.host_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL stv_rdata got %h want deadbeef", bus.host_rdata); end
    if (bus.starve_cnt !== 8'd20) begin errors++; $display("FAIL stv_cnt_hold got %0d want 20", bus.starve_cnt); end
    if (bus.host_starve !== 1'b1) begin errors++; $display("FAIL stv_flag_hold got %0b want 1", bus.host_starve); end
    next_cycle();
  endtask

  task automatic test_collision();
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 32'h40; bus.host_wdata = 32'h2;
    next_cycle();
    bus.host_req = 0;
    bus.cpu_mem_we = 1; bus.cpu_mem_wa = 32'h40; bus.cpu_mem_din = 32'h1;
    @(negedge clk);
    checks += 3;
    if (bus.ram_din !== 32'h1) begin errors++; $display("FAIL col_cpu_din got %h want 1", bus.ram_din); end
    if (bus.cpu_mem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL col_cpu_rd got %h want deadbeef", bus.cpu_mem_data); end
    if (bus.host_starve !== 1'b0) begin errors++; $display("FAIL col_starve_clr got %0b want 0", bus.host_starve); end
    next_cycle();
    bus.cpu_mem_we = 0;
    @(negedge clk);
    checks += 2;
    if (mem[8'h40] !== 32'h1) begin errors++; $display("FAIL col_mid_mem got %h want 1", mem[8'h40]); end
    if (bus.ram_din !== 32'h2 || bus.ram_we !== 1'b1) begin errors++; $display("FAIL col_host_din got %h/%0b want 2/1", bus.ram_din, bus.ram_we); end
    next_cycle();
    @(negedge clk);
    checks += 2;
    if (bus.host_ack !== 1'b1) begin errors++; $display("FAIL col_ack got %0b want 1", bus.host_ack); end
    if (mem[8'h40] !== 32'h2) begin errors++; $display("FAIL col_final got %h want 2", mem[8'h40]); end
    next_cycle();
  endtask

  task automatic test_halt();
    bus.cpu_halt = 1; bus.cpu_mem_we = 1; bus.cpu_mem_wa = 32'h40; bus.cpu_mem_din = 32'h55;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL hlt_idle_we got %0b want 0", bus.ram_we); end
    next_cycle();
    bus.host_req = 0;
    @(negedge clk);
    checks += 2;
    if (bus.host_busy !== 1'b1) begin errors++; $display("FAIL hlt_busy got %0b want 1", bus.host_busy); end
    if (bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h40) begin errors++; $display("FAIL hlt_ram got we=%0b a=%h want 0/40", bus.ram_we, bus.ram_addr); end
    next_cycle();
    @(negedge clk);
    checks += 3;
    if (bus.host_ack !== 1'b1) begin errors++; $display("FAIL hlt_ack got %0b want 1", bus.host_ack); end
    if (bus.host_rdata !== 32'h2) begin errors++; $display("FAIL hlt_rdata got %h want 2", bus.host_rdata); end
    if (bus.starve_cnt !== 8'd0) begin errors++; $display("FAIL hlt_cnt got %0d want 0", bus.starve_cnt); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (mem[8'h40] !== 32'h2) begin errors++; $display("FAIL hlt_mem got %h want 2", mem[8'h40]); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 32'h20; bus.host_wdata = 32'h1111;
    next_cycle();
    bus.host_addr = 32'h24; bus.host_wdata = 32'h2222;
    @(negedge clk);
    checks++;
    if (bus.ram_addr !== 32'h20 || bus.ram_din !== 32'h1111) begin errors++; $display("FAIL b2b_held got %h/%h want 20/1111", bus.ram_addr, bus.ram_din); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.host_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %0b want 1", bus.host_ack); end
    next_cycle();
    bus.host_req = 0;
    @(negedge clk);
    checks += 2;
    if (bus.host_busy !== 1'b1 || bus.host_ack !== 1'b0) begin errors++; $display("FAIL b2b_pend2 got busy=%0b ack=%0b want 1/0", bus.host_busy, bus.host_ack); end
    if (bus.ram_addr !== 32'h24 || bus.ram_din !== 32'h2222) begin errors++; $display("FAIL b2b_req2 got %h/%h want 24/2222", bus.ram_addr, bus.ram_din); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.host_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got %0b want 1", bus.host_ack); end
    next_cycle();
    @(negedge clk);
    checks += 2;
    if (bus.host_ack !== 1'b0 || bus.host_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got ack=%0b busy=%0b want 0/0", bus.host_ack, bus.host_busy); end
    if (mem[8'h20] !== 32'h1111 || mem[8'h24] !== 32'h2222) begin errors++; $display("FAIL b2b_mem got %h/%h want 1111/2222", mem[8'h20], mem[8'h24]); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 32'h30; bus.host_wdata = 32'hBAD;
    bus.cpu_mem_read = 1; bus.cpu_mem_wa = 32'h10;
    next_cycle();
    bus.host_req = 0;
    @(negedge clk);
    checks++;
    if (bus.host_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %0b want 1", bus.host_busy); end
    #1;
    rst = 1; bus.cpu_mem_read = 0;
    #1;
    checks += 4;
    if (bus.host_busy !== 1'b0 || bus.host_ack !== 1'b0) begin errors++; $display("FAIL rmid_async got busy=%0b ack=%0b want 0/0", bus.host_busy, bus.host_ack); end
    if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rmid_ram_we got %0b want 0", bus.ram_we); end
    if (bus.host_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got %h want 0", bus.host_rdata); end
    if (bus.starve_cnt !== 8'd0) begin errors++; $display("FAIL rmid_cnt got %0d want 0", bus.starve_cnt); end
    next_cycle();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.host_ack !== 1'b0 || bus.host_busy !== 1'b0) begin errors++; $display("FAIL rmid_post got ack=%0b busy=%0b want 0/0", bus.host_ack, bus.host_busy); end
      next_cycle();
    end
    checks++;
    if (mem[8'h30] !== 32'h0) begin errors++; $display("FAIL rmid_mem got %h want 0", mem[8'h30]); end
  endtask

  // Model: a request is served on the first cycle after acceptance in which
  // the CPU is not accessing memory; every blocked cycle is a lost cycle.
  task automatic test_random();
    logic [31:0] em [256];
    bit pend, exp_ack, hw, act;
    int lost;
    logic [7:0]  ha, cwa, haddr;
    logic [31:0] hd, exp_rd, cdin, hwd;
    bit cwe, crd, chalt, hreq, hwe;
    int bad_idx;
    for (int i = 0; i < 256; i++) em[i] = mem[i];
    pend = 0; exp_ack = 0; lost = 0; exp_rd = '0; hw = 0; ha = '0; hd = '0;
    for (int c = 0; c < 403; c++) begin
      if (c < 400) begin
        act   = ($urandom_range(0, 9) < 6);
        cwe   = act && $urandom_range(0, 1) == 1;
        crd   = act && !cwe;
        chalt = ($urandom_range(0, 9) == 0);
        cwa   = 8'($urandom);
        cdin  = $urandom;
        hreq  = ($urandom_range(0, 9) < 3);
        hwe   = $urandom_range(0, 1) == 1;
        haddr = 8'($urandom);
        hwd   = $urandom;
      end else begin
        cwe = 0; crd = 0; chalt = 0; hreq = 0; hwe = 0; cwa = '0; cdin = '0; haddr = '0; hwd = '0;
      end
      bus.cpu_mem_we = cwe; bus.cpu_mem_read = crd; bus.cpu_halt = chalt;
      bus.cpu_mem_wa = {24'h0, cwa}; bus.cpu_mem_din = cdin;
      bus.host_req = hreq; bus.host_we = hwe; bus.host_addr = {24'h0, haddr}; bus.host_wdata = hwd;
      act = (cwe || crd) && !chalt;
      @(negedge clk);
      checks += 5;
      if (bus.host_busy !== pend) begin errors++; $display("FAIL rnd_busy c%0d got %0b want %0b", c, bus.host_busy, pend); end
      if (bus.host_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack c%0d got %0b want %0b", c, bus.host_ack, exp_ack); end
      if (bus.starve_cnt !== 8'(lost > 255 ? 255 : lost)) begin errors++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, bus.starve_cnt, lost); end
      if (bus.host_starve !== (lost >= 16)) begin errors++; $display("FAIL rnd_starve c%0d got %0b want %0b", c, bus.host_starve, lost >= 16); end
      if (bus.host_rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata c%0d got %h want %h", c, bus.host_rdata, exp_rd); end
      if (act) begin
        checks++;
        if (bus.cpu_mem_data !== em[cwa]) begin errors++; $display("FAIL rnd_cpu_rd c%0d got %h want %h", c, bus.cpu_mem_data, em[cwa]); end
      end
      exp_ack = 0;
      if (pend) begin
        if (act) begin
          if (lost < 255) lost++;
          if (cwe) em[cwa] = cdin;
        end else begin
          if (hw) em[ha] = hd; else exp_rd = em[ha];
          pend = 0; exp_ack = 1;
        end
      end else begin
        if (act && cwe) em[cwa] = cdin;
        if (hreq) begin pend = 1; lost = 0; hw = hwe; ha = haddr; hd = hwd; end
      end
      next_cycle();
    end
    bad_idx = -1;
    for (int i = 0; i < 256; i++) if (mem[i] !== em[i] && bad_idx < 0) bad_idx = i;
    checks++;
    if (bad_idx >= 0) begin errors++; $display("FAIL rnd_mem[%0d] got %h want %h", bad_idx, mem[bad_idx], em[bad_idx]); end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_host_write();
    test_starve();
    test_collision();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
